// File: rtl/link_fifo_pkg.sv
// rtl/link_fifo_pkg.sv - shared link FIFO widths, also used by the pe processing element
package link_fifo_pkg;

  localparam int LINK_DATA_WIDTH = 128;
  localparam int LINK_ADDR_WIDTH = 4;

  function automatic int link_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/link_fifo_mem.sv
// rtl/link_fifo_mem.sv - FIFO storage: one synchronous write port, one asynchronous read port
module link_fifo_mem
  import link_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH,
  parameter int ADDR_WIDTH = LINK_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = link_depth(ADDR_WIDTH);

  // No reset: contents are meaningless until written.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - first-word-fall-through link FIFO with sticky overflow/underflow flags
module link_fifo
  import link_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH,
  parameter int ADDR_WIDTH = LINK_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  output logic                  full,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  push;
  logic                  pop;

  // Flags come only from registered count, so wr/rd never reach full/vld.
  assign vld   = (cnt != '0);
  assign full  = (cnt == CNT_DEPTH);
  assign count = cnt;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  assign push = wr & ~full;
  assign pop  = rd & vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      if (wr && full) begin
        ovf_q <= 1'b1;
      end
      if (rd && !vld) begin
        udf_q <= 1'b1;
      end
    end
  end

  link_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wptr),
    .wdata(din),
    .raddr(rptr),
    .rdata(dout)
  );

endmodule

// File: tb/tb_link_fifo.sv
// tb/tb_link_fifo.sv - self-checking bench for link_fifo: vector table, corner sequences, random vs queue model
module tb_link_fifo;

  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full;
  logic          vld;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  always #5 clk = ~clk;

  link_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr),
    .full (full),
    .din  (din),
    .rd   (rd),
    .vld  (vld),
    .dout (dout),
    .count(count),
    .ovf  (ovf),
    .udf  (udf)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, "_count"}, DW'(count), DW'(q.size()));
    check({tag, "_vld"}, DW'(vld), DW'(q.size() != 0));
    check({tag, "_full"}, DW'(full), DW'(q.size() == DEPTH));
    check({tag, "_ovf"}, DW'(ovf), DW'(m_ovf));
    check({tag, "_udf"}, DW'(udf), DW'(m_udf));
    if (q.size() != 0) check({tag, "_dout"}, dout, q[0]);
  endtask

  // One clock: drive, let the edge happen, advance the queue model, compare 1 time unit later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit was_full;
    bit was_vld;
    was_full = (q.size() == DEPTH);
    was_vld  = (q.size() != 0);
    wr = w; rd = r; din = d;
    @(posedge clk);
    if (r) begin
      if (was_vld) void'(q.pop_front());
      else m_udf = 1'b1;
    end
    if (w) begin
      if (!was_full) q.push_back(d);
      else m_ovf = 1'b1;
    end
    #1;
    wr = 1'b0; rd = 1'b0;
    model_check(tag);
  endtask

  // Called 1 time unit after a rising edge; the reset edge lands mid-cycle.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    check({tag, "_async_vld"}, DW'(vld), '0);
    check({tag, "_async_full"}, DW'(full), '0);
    check({tag, "_async_count"}, DW'(count), '0);
    check({tag, "_async_ovf"}, DW'(ovf), '0);
    check({tag, "_async_udf"}, DW'(udf), '0);
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       vld;
    logic       full;
    logic       ovf;
    logic       udf;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int wbias;
    logic [DW-1:0] rdat;

    tbl[0] = '{1'b1, 1'b0, 8'h01, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[1] = '{1'b1, 1'b0, 8'h02, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[2] = '{1'b1, 1'b0, 8'h03, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{1'b1, 1'b1, 8'hAA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

    #12;
    check("reset_vld", DW'(vld), '0);
    check("reset_full", DW'(full), '0);
    check("reset_count", DW'(count), '0);
    check("reset_ovf", DW'(ovf), '0);
    check("reset_udf", DW'(udf), '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wr, tbl[i].rd, DW'(tbl[i].din), $sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d_count", i), DW'(count), DW'(tbl[i].cnt));
      check($sformatf("tbl%0d_vld", i), DW'(vld), DW'(tbl[i].vld));
      check($sformatf("tbl%0d_full", i), DW'(full), DW'(tbl[i].full));
      check($sformatf("tbl%0d_ovf", i), DW'(ovf), DW'(tbl[i].ovf));
      check($sformatf("tbl%0d_udf", i), DW'(udf), DW'(tbl[i].udf));
      if (tbl[i].vld) check($sformatf("tbl%0d_dout", i), dout, DW'(tbl[i].dout));
    end

    // Fill to 16, refused 17th write, drain.
    async_reset("fill");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
    check("fill_full", DW'(full), DW'(1));
    check("fill_count", DW'(count), DW'(16));
    step(1'b1, 1'b0, DW'(8'hFF), "ovf17");
    check("ovf17_ovf", DW'(ovf), DW'(1));
    check("ovf17_count", DW'(count), DW'(16));
    for (int i = 0; i < DEPTH; i++) begin
      rdat = dout;
      check($sformatf("drain%0d_dout", i), rdat, DW'(i));
      step(1'b0, 1'b1, '0, "drain");
    end
    check("drain_vld", DW'(vld), '0);

    // Full + wr + rd: pop happens, write refused.
    async_reset("fullrw");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i + 100), "fullrw_fill");
    step(1'b1, 1'b1, DW'(8'hEE), "fullrw");
    check("fullrw_count", DW'(count), DW'(15));
    check("fullrw_ovf", DW'(ovf), DW'(1));
    check("fullrw_dout", dout, DW'(101));

    // Steady wr+rd at depth 8 for 40 cycles; pointers wrap.
    async_reset("stream");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i), "stream_fill");
    for (int i = 0; i < 40; i++) begin
      check($sformatf("stream%0d_dout", i), dout, DW'(i));
      step(1'b1, 1'b1, DW'(i + 8), "stream");
      check($sformatf("stream%0d_count", i), DW'(count), DW'(8));
    end

    // Mid-operation async reset, then first push becomes head.
    async_reset("mid_pre");
    step(1'b0, 1'b1, '0, "mid_udf");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(i + 50), "mid_fill");
    async_reset("mid");
    step(1'b1, 1'b0, DW'(8'h77), "mid_push");
    check("mid_push_dout", dout, DW'(8'h77));
    check("mid_push_count", DW'(count), DW'(1));

    // Random traffic with a drifting write bias so both full and empty are visited.
    async_reset("rand");
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) wbias = (i / 100) % 2 == 0 ? 80 : 20;
      step($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < 50,
           {$urandom, $urandom, $urandom, $urandom}, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
